entity_frame_buffer: RTL and testbench

Double-buffered entity slot table upstream of `PictureProcessingUnit`. Game logic writes entity records into a shadow bank at any time. The shadow bank is copied to the active bank only at the first vertical-blank line after a commit request, so the PPU sees a frame-stable set of 15 slots. The block drives the PPU's `entity_1`..`entity_15` inputs directly.

---
 rtl/entity_frame_buffer_pkg.sv | 27 ++
 rtl/entity_slot_bank.sv | 32 +++
 rtl/entity_frame_buffer.sv | 159 +++++++++++++++
 tb/tb_entity_frame_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/entity_frame_buffer_pkg.sv
// Shared definitions for the entity frame buffer and the PPU entity record format.
// Holds the empty record, the record field offsets and the default swap line.
package entity_frame_buffer_pkg;

    localparam int DEF_NUM_SLOTS = 15;
    localparam int DEF_ENTITY_W  = 18;
    localparam int DEF_SWAP_LINE = 480;

    // ID field of 4'hF marks a slot the PPU must skip.
    localparam logic [17:0] EMPTY_ENTITY = 18'h3F000;

    localparam int ID_MSB     = 17;
    localparam int ID_LSB     = 14;
    localparam int ORIENT_MSB = 13;
    localparam int ORIENT_LSB = 12;
    localparam int LOC_MSB    = 11;
    localparam int LOC_LSB    = 4;
    localparam int FLIP_BIT   = 3;
    localparam int COUNT_MSB  = 2;
    localparam int COUNT_LSB  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

endpackage

// File: rtl/entity_slot_bank.sv
// Register array of entity slots with one indexed write port and a parallel
// load port used for the shadow-to-active copy.
module entity_slot_bank
    import entity_frame_buffer_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int ENTITY_W  = DEF_ENTITY_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [3:0]                         wr_idx,
    input  logic [ENTITY_W-1:0]                wr_data,
    input  logic                               load_en,
    input  logic [NUM_SLOTS-1:0][ENTITY_W-1:0] load_data,
    output logic [NUM_SLOTS-1:0][ENTITY_W-1:0] slots
);

    // A parallel load wins over the indexed write; the top never asks for both.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= ENTITY_W'(EMPTY_ENTITY);
            end
        end else if (load_en) begin
            slots <= load_data;
        end else if (wr_en && ({28'd0, wr_idx} < NUM_SLOTS)) begin
            slots[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/entity_frame_buffer.sv
// Double-buffered entity slot table: game logic fills the shadow bank, which is
// published to the active bank (the PPU entity inputs) on the first vblank line.
module entity_frame_buffer
    import entity_frame_buffer_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int ENTITY_W  = DEF_ENTITY_W,
    parameter int SWAP_LINE = DEF_SWAP_LINE
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [9:0]          counter_V,
    input  logic                wr_valid,
    input  logic [3:0]          wr_slot,
    input  logic [ENTITY_W-1:0] wr_data,
    output logic                wr_ready,
    output logic                wr_err,
    input  logic                commit,
    input  logic                clear,
    output logic                commit_pending,
    output logic                frame_tick,
    output logic                swapped,
    output logic [ENTITY_W-1:0] entity_1,
    output logic [ENTITY_W-1:0] entity_2,
    output logic [ENTITY_W-1:0] entity_3,
    output logic [ENTITY_W-1:0] entity_4,
    output logic [ENTITY_W-1:0] entity_5,
    output logic [ENTITY_W-1:0] entity_6,
    output logic [ENTITY_W-1:0] entity_7,
    output logic [ENTITY_W-1:0] entity_8,
    output logic [ENTITY_W-1:0] entity_9,
    output logic [ENTITY_W-1:0] entity_10,
    output logic [ENTITY_W-1:0] entity_11,
    output logic [ENTITY_W-1:0] entity_12,
    output logic [ENTITY_W-1:0] entity_13,
    output logic [ENTITY_W-1:0] entity_14,
    output logic [ENTITY_W-1:0] entity_15
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_SLOTS - 1);
    localparam logic [9:0] SWAP_V   = 10'(SWAP_LINE);

    fb_state_t state, state_next;
    logic [3:0] clr_idx, clr_idx_next;
    logic [9:0] prev_V;
    logic swap_edge, do_swap, wr_accept;
    logic shadow_we;
    logic [3:0] shadow_idx;
    logic [ENTITY_W-1:0] shadow_data;
    logic [NUM_SLOTS-1:0][ENTITY_W-1:0] shadow_slots, active_slots;

    assign wr_ready  = (state == IDLE);
    assign wr_accept = wr_valid && wr_ready;
    assign swap_edge = (counter_V == SWAP_V) && (prev_V != SWAP_V);
    // A commit arriving on the swap edge itself still publishes this frame.
    assign do_swap   = swap_edge && (state == IDLE) && (commit_pending || commit);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state   <= IDLE;
            clr_idx <= 4'd0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        shadow_we    = 1'b0;
        shadow_idx   = wr_slot;
        shadow_data  = wr_data;
        case (state)
            IDLE: begin
                if (wr_accept && (wr_slot != 4'hF)) begin
                    shadow_we = 1'b1;
                end
                if (clear) begin
                    state_next   = CLEAR;
                    clr_idx_next = 4'd0;
                end
            end
            CLEAR: begin
                shadow_we   = 1'b1;
                shadow_idx  = clr_idx;
                shadow_data = ENTITY_W'(EMPTY_ENTITY);
                if (clear) begin
                    clr_idx_next = 4'd0;
                end else if (clr_idx == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_idx_next = 4'd0;
                end else begin
                    clr_idx_next = clr_idx + 4'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_idx_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            prev_V         <= 10'd0;
            commit_pending <= 1'b0;
            frame_tick     <= 1'b0;
            swapped        <= 1'b0;
            wr_err         <= 1'b0;
        end else begin
            prev_V         <= counter_V;
            commit_pending <= do_swap ? 1'b0 : (commit_pending || commit);
            frame_tick     <= swap_edge;
            swapped        <= do_swap;
            wr_err         <= wr_accept && (wr_slot == 4'hF);
        end
    end

    // The copy reads the registered shadow, so a same-cycle write misses it.
    entity_slot_bank #(.NUM_SLOTS(NUM_SLOTS), .ENTITY_W(ENTITY_W)) shadow_bank (
        .clk       (clk_in),
        .reset     (reset),
        .wr_en     (shadow_we),
        .wr_idx    (shadow_idx),
        .wr_data   (shadow_data),
        .load_en   (1'b0),
        .load_data ('0),
        .slots     (shadow_slots)
    );

    entity_slot_bank #(.NUM_SLOTS(NUM_SLOTS), .ENTITY_W(ENTITY_W)) active_bank (
        .clk       (clk_in),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_idx    (4'd0),
        .wr_data   ('0),
        .load_en   (do_swap),
        .load_data (shadow_slots),
        .slots     (active_slots)
    );

    assign entity_1  = active_slots[0];
    assign entity_2  = active_slots[1];
    assign entity_3  = active_slots[2];
    assign entity_4  = active_slots[3];
    assign entity_5  = active_slots[4];
    assign entity_6  = active_slots[5];
    assign entity_7  = active_slots[6];
    assign entity_8  = active_slots[7];
    assign entity_9  = active_slots[8];
    assign entity_10 = active_slots[9];
    assign entity_11 = active_slots[10];
    assign entity_12 = active_slots[11];
    assign entity_13 = active_slots[12];
    assign entity_14 = active_slots[13];
    assign entity_15 = active_slots[14];

endmodule

// File: tb/tb_entity_frame_buffer.sv
// Self-checking bench for entity_frame_buffer: a frame-level reference model
// checked every cycle, plus directed literal checks following the test plan.
module tb_entity_frame_buffer;

    localparam logic [17:0] EMPTY = 18'h3F000;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [9:0]  counter_V;
    logic        wr_valid;
    logic [3:0]  wr_slot;
    logic [17:0] wr_data;
    logic        wr_ready;
    logic        wr_err;
    logic        commit;
    logic        clear;
    logic        commit_pending;
    logic        frame_tick;
    logic        swapped;
    logic [17:0] ent [15];

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk_in = ~clk_in;

    entity_frame_buffer dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .counter_V      (counter_V),
        .wr_valid       (wr_valid),
        .wr_slot        (wr_slot),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .wr_err         (wr_err),
        .commit         (commit),
        .clear          (clear),
        .commit_pending (commit_pending),
        .frame_tick     (frame_tick),
        .swapped        (swapped),
        .entity_1       (ent[0]),
        .entity_2       (ent[1]),
        .entity_3       (ent[2]),
        .entity_4       (ent[3]),
        .entity_5       (ent[4]),
        .entity_6       (ent[5]),
        .entity_7       (ent[6]),
        .entity_8       (ent[7]),
        .entity_9       (ent[8]),
        .entity_10      (ent[9]),
        .entity_11      (ent[10]),
        .entity_12      (ent[11]),
        .entity_13      (ent[12]),
        .entity_14      (ent[13]),
        .entity_15      (ent[14])
    );

    // Reference model: two banks of records, a pending flag, and a count of
    // clear cycles still to run. Updated once per rising edge from the inputs.
    logic [17:0] m_shadow [15];
    logic [17:0] m_active [15];
    bit m_pending, m_tick, m_swapped, m_err;
    int m_clear_left;
    int m_prev_v;
    bit edge_now, in_clear, accepted, publish;

    always @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                m_shadow[i] = EMPTY;
                m_active[i] = EMPTY;
            end
            m_pending    = 1'b0;
            m_tick       = 1'b0;
            m_swapped    = 1'b0;
            m_err        = 1'b0;
            m_clear_left = 0;
            m_prev_v     = 0;
        end else begin
            edge_now = (int'(counter_V) == 480) && (m_prev_v != 480);
            in_clear = (m_clear_left > 0);
            accepted = wr_valid && !in_clear;
            publish  = edge_now && !in_clear && (m_pending || commit);
            if (publish) begin
                for (int i = 0; i < 15; i++) m_active[i] = m_shadow[i];
            end
            m_tick    = edge_now;
            m_swapped = publish;
            m_err     = accepted && (wr_slot == 4'd15);
            m_pending = publish ? 1'b0 : (m_pending || commit);
            if (in_clear) begin
                m_shadow[15 - m_clear_left] = EMPTY;
            end else if (accepted && (wr_slot != 4'd15)) begin
                m_shadow[wr_slot] = wr_data;
            end
            if (clear) m_clear_left = 15;
            else if (in_clear) m_clear_left = m_clear_left - 1;
            m_prev_v = int'(counter_V);
        end
    end

    task automatic checkOutput(input string name, input logic [17:0] actual, input logic [17:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk_in) begin
        if (check_en) begin
            for (int i = 0; i < 15; i++) begin
                checkOutput($sformatf("model_entity_%0d", i + 1), ent[i], m_active[i]);
            end
            checkOutput("model_wr_ready", {17'd0, wr_ready}, {17'd0, (m_clear_left == 0)});
            checkOutput("model_wr_err", {17'd0, wr_err}, {17'd0, m_err});
            checkOutput("model_commit_pending", {17'd0, commit_pending}, {17'd0, m_pending});
            checkOutput("model_frame_tick", {17'd0, frame_tick}, {17'd0, m_tick});
            checkOutput("model_swapped", {17'd0, swapped}, {17'd0, m_swapped});
        end
    end

    // Advance a number of cycles; inputs change 2 time units after each edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic checkAllEmpty(input string name);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("%s_entity_%0d", name, i + 1), ent[i], EMPTY);
        end
    endtask

    initial begin
        reset     = 1'b1;
        counter_V = 10'd0;
        wr_valid  = 1'b0;
        wr_slot   = 4'd0;
        wr_data   = 18'd0;
        commit    = 1'b0;
        clear     = 1'b0;

        // Reset state
        applyStimulus(2);
        reset    = 1'b0;
        check_en = 1'b1;
        checkAllEmpty("reset");
        checkOutput("reset_wr_ready", {17'd0, wr_ready}, 18'd1);
        checkOutput("reset_frame_tick", {17'd0, frame_tick}, 18'd0);
        checkOutput("reset_swapped", {17'd0, swapped}, 18'd0);
        checkOutput("reset_wr_err", {17'd0, wr_err}, 18'd0);
        checkOutput("reset_pending", {17'd0, commit_pending}, 18'd0);

        // Write, commit, swap
        counter_V = 10'd100;
        wr_valid = 1'b1; wr_slot = 4'd3; wr_data = 18'h0A123;
        applyStimulus(1);
        wr_valid = 1'b0; commit = 1'b1;
        applyStimulus(1);
        commit = 1'b0;
        checkOutput("commit_pending_set", {17'd0, commit_pending}, 18'd1);
        counter_V = 10'd479;
        applyStimulus(3);
        checkOutput("pre_swap_entity_4", ent[3], EMPTY);
        counter_V = 10'd480;
        applyStimulus(1);
        checkOutput("swap_entity_4", ent[3], 18'h0A123);
        checkOutput("swap_swapped", {17'd0, swapped}, 18'd1);
        checkOutput("swap_tick", {17'd0, frame_tick}, 18'd1);
        checkOutput("swap_pending_clear", {17'd0, commit_pending}, 18'd0);
        applyStimulus(1);
        checkOutput("swap_swapped_once", {17'd0, swapped}, 18'd0);
        checkOutput("swap_tick_once", {17'd0, frame_tick}, 18'd0);

        // Swap edge without commit, counter held at the swap line
        counter_V = 10'd0;
        applyStimulus(1);
        counter_V = 10'd479;
        applyStimulus(1);
        counter_V = 10'd480;
        applyStimulus(1);
        checkOutput("nocommit_tick", {17'd0, frame_tick}, 18'd1);
        checkOutput("nocommit_swapped", {17'd0, swapped}, 18'd0);
        checkOutput("nocommit_entity_4", ent[3], 18'h0A123);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("hold_no_tick", {17'd0, frame_tick}, 18'd0);
        end

        // Clear collides with a swap edge on its fifth cycle
        counter_V = 10'd100;
        applyStimulus(1);
        commit = 1'b1;
        applyStimulus(1);
        commit = 1'b0; clear = 1'b1;
        applyStimulus(1);
        clear = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("clear_busy_%0d", i), {17'd0, wr_ready}, 18'd0);
            if (i == 5) begin
                checkOutput("clear_edge_tick", {17'd0, frame_tick}, 18'd1);
                checkOutput("clear_edge_no_swap", {17'd0, swapped}, 18'd0);
                checkOutput("clear_edge_pending", {17'd0, commit_pending}, 18'd1);
                checkOutput("clear_edge_entity_4", ent[3], 18'h0A123);
            end
            if (i == 4) counter_V = 10'd480;
            applyStimulus(1);
        end
        checkOutput("clear_done_ready", {17'd0, wr_ready}, 18'd1);
        checkOutput("clear_done_pending", {17'd0, commit_pending}, 18'd1);
        counter_V = 10'd0;
        applyStimulus(1);
        counter_V = 10'd480;
        applyStimulus(1);
        checkOutput("retry_swapped", {17'd0, swapped}, 18'd1);
        checkAllEmpty("retry");

        // Write coincident with swap edge
        counter_V = 10'd100;
        wr_valid = 1'b1; wr_slot = 4'd0; wr_data = 18'h05555;
        applyStimulus(1);
        wr_valid = 1'b0; commit = 1'b1;
        applyStimulus(1);
        commit = 1'b0; counter_V = 10'd479;
        applyStimulus(1);
        counter_V = 10'd480;
        wr_valid = 1'b1; wr_slot = 4'd0; wr_data = 18'h01234;
        applyStimulus(1);
        wr_valid = 1'b0;
        checkOutput("coincide_entity_1_old", ent[0], 18'h05555);
        checkOutput("coincide_swapped", {17'd0, swapped}, 18'd1);
        counter_V = 10'd100; commit = 1'b1;
        applyStimulus(1);
        commit = 1'b0; counter_V = 10'd480;
        applyStimulus(1);
        checkOutput("second_entity_1_new", ent[0], 18'h01234);

        // Invalid slot write
        counter_V = 10'd100;
        wr_valid = 1'b1; wr_slot = 4'd15; wr_data = 18'h00777;
        applyStimulus(1);
        wr_valid = 1'b0;
        checkOutput("bad_slot_err", {17'd0, wr_err}, 18'd1);
        applyStimulus(1);
        checkOutput("bad_slot_err_once", {17'd0, wr_err}, 18'd0);
        checkOutput("bad_slot_entity_1", ent[0], 18'h01234);

        // Reset in the middle of a clear with a commit pending
        commit = 1'b1;
        applyStimulus(1);
        commit = 1'b0; clear = 1'b1;
        applyStimulus(1);
        clear = 1'b0;
        applyStimulus(3);
        checkOutput("midclear_busy", {17'd0, wr_ready}, 18'd0);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkAllEmpty("midreset");
        checkOutput("midreset_ready", {17'd0, wr_ready}, 18'd1);
        checkOutput("midreset_pending", {17'd0, commit_pending}, 18'd0);
        applyStimulus(2);
        checkOutput("post_reset_ready", {17'd0, wr_ready}, 18'd1);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
